regfile_read_arbiter: RTL
=========================

# regfile_read_arbiter

Shares the single 32-to-1 register-file read path between two requesters, A and B. Requester A is the rs operand fetch; requester B is the rt operand fetch or a debug reader. A round-robin valid/ready handshake selects one requester per cycle and drives its 5-bit address onto the mux select (`Ard`). The block captures the mux output (`Dout`) one cycle later into a per-requester response register with a valid pulse. It sits between the decode stage and the register-file read mux.

## Interface
- `DATA_W`, 32, width of register data and of the mux output
- `ADDR_W`, 5, width of the register address; 32 registers
- `Clk`  in  1  single clock; all state updates on the rising edge
- `Rst`  in  1  reset, synchronous and active-high
- `Stall`  in  1  pipeline hold: no grants, all state frozen
- `ReqA`  in  1  requester A read request
- `ArdA`  in  ADDR_W  requester A register address; stable while `ReqA` is high and `GntA` is low
- `GntA`  out  1  combinational grant to A; the transfer occurs on the edge where `ReqA` and `GntA` are both high
- `RvalidA`  out  1  one-cycle pulse: `RdataA` holds a fresh result
- `RdataA`  out  DATA_W  last read result for A; holds until A's next response
- `ReqB`, `ArdB`, `GntB`, `RvalidB`, `RdataB`: same as the A ports, for requester B
- `MuxArd`  out  ADDR_W  registered address to the mux `Ard` input
- `MuxDout`  in  DATA_W  mux `Dout`, combinational from `MuxArd`
- `Busy`  out  1  high while a read is in flight (state READ)

## Operation
- **States.** IDLE and READ.
  - IDLE: no read in flight.
  - READ: `MuxArd` holds the granted address, and the data is captured at the end of this cycle.
- **Round-robin pointer `Last`.** Records the last granted requester. Reset value is B, so A wins the first tie.
- **Grant logic (combinational)**, valid in any state when `Stall` is 0:
  - only one requester requesting: that requester is granted;
  - both requesting: the requester other than `Last` is granted;
  - `Stall` is 1: both grants are 0.
- **Transfer edge** (Req and Gnt both high for one requester):
  - `MuxArd` is loaded with that requester's address;
  - a 1-bit `Owner` register records the requester;
  - `Last` is set to that requester;
  - the next state is READ.
- **In READ**, on the next non-stalled edge:
  - `MuxDout` is captured into `Rdata` of `Owner`;
  - `Rvalid` of `Owner` pulses for the following cycle.
- **Back-to-back reads.** A new grant may occur on the same edge as a capture; the state stays READ. Throughput is one read per cycle.
- **Leaving READ.** If no transfer occurs on a capture edge, the state returns to IDLE. `MuxArd` holds its last value.
- **Rdata hold.** `Rdata` of the requester that is not `Owner` is unchanged.
- **Stall in READ.** The capture is deferred. `MuxArd`, `Owner` and the state are held. `Rvalid` outputs are 0 while stalled.
- **Address range.** All addresses 0..31 are legal. Register 0 receives no special treatment here.

## Timing
- **Reset values** (on the edge where `Rst`=1; `Rst` overrides `Stall`):
  - state IDLE, `Last`=B, `Owner`=A;
  - `MuxArd`=0, `RdataA`=`RdataB`=0;
  - `RvalidA`=`RvalidB`=0, `Busy`=0.
- **Latency.** Transfer on edge n → `MuxArd` valid after edge n → data captured on edge n+1 → `Rvalid` high for the cycle after edge n+1. Without stalls, latency is 2 edges.
- **Reset mid-read.** The in-flight result is discarded and no `Rvalid` is issued.
- **Simultaneous events.**
  - A capture for A and a new grant for A on the same edge: `RvalidA` pulses, and A's next result follows one cycle later.
  - A single requester holding `Req` continuously is granted every cycle.
- **Requester rule.** A request keeps `Req` and `Ard` stable until its grant is seen. A request withdrawn before its grant is legal and is simply not served.

## Structure
- **Package `regfile_pkg`** holds:
  - `DATA_W`, `ADDR_W`;
  - the state encoding (IDLE=0, READ=1);
  - requester IDs (A=0, B=1).
- **Sub-module `rr_arb2`**: combinational two-way round-robin.
  - Inputs: `req[1:0]`, `last`, `stall`.
  - Output: `gnt[1:0]`, one-hot or zero.
  - The top level holds the FSM, `MuxArd`, `Owner`, `Last` and the response registers.
- **Bench wiring.** The bench instantiates the existing 32-to-1 mux with Din_i = i.

## Test plan
- **Reset, idle.** `Rst` high for 2 cycles, then low with no requests → all outputs 0, `Busy`=0, `MuxArd`=0.
- **Single read.** `ReqA`=1, `ArdA`=13 for one transfer:
  - `GntA` high the same cycle;
  - `MuxArd`=13 after the edge;
  - `RvalidA` pulses 2 edges after the transfer with `RdataA`=13;
  - `RdataB` unchanged at 0.
- **Contention.** `ReqA` (`ArdA`=5) and `ReqB` (`ArdB`=22) both held continuously:
  - grants alternate A, B, A, …;
  - responses are 5, 22, 5, … on alternating cycles;
  - `Busy` stays 1.
- **Back-to-back single requester.** `ReqB` held with `ArdB`=0, 1, 31 on consecutive cycles → `RvalidB` high 3 consecutive cycles with data 0, 1, 31.
- **Stall in READ.** Assert `Stall` for 3 cycles right after A's transfer (`ArdA`=7):
  - no `Rvalid`, both grants 0, `MuxArd` held at 7;
  - `RvalidA` with 7 one cycle after `Stall` drops.
- **Reset mid-read.** `Rst` on the edge after B's transfer (`ArdB`=9) → no `RvalidB`, `RdataB`=0, state IDLE, A wins the next tie.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: widths, FSM encoding and requester ids shared
// by the register-file read arbiter and its round-robin core.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } rid_t;

    function automatic rid_t other(input rid_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/regfile_read_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
// On a tie the requester that was not granted last wins.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic [1:0] req,
    input  rid_t       last,
    input  logic       stall,
    output logic [1:0] gnt
);

    rid_t tie_win;

    assign tie_win = other(last);

    always_comb begin
        gnt = 2'b00;
        if (!stall) begin
            unique case (1'b1)
                (req == 2'b11): gnt = (tie_win == REQ_B) ? 2'b10 : 2'b01;
                (req == 2'b01): gnt = 2'b01;
                (req == 2'b10): gnt = 2'b10;
                default:        gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: shares the 32-to-1 register-file read mux
// between two requesters; one read per cycle, two-edge latency.
module regfile_read_arbiter
    import regfile_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              ReqA,
    input  logic [ADDR_W-1:0] ArdA,
    output logic              GntA,
    output logic              RvalidA,
    output logic [DATA_W-1:0] RdataA,
    input  logic              ReqB,
    input  logic [ADDR_W-1:0] ArdB,
    output logic              GntB,
    output logic              RvalidB,
    output logic [DATA_W-1:0] RdataB,
    output logic [ADDR_W-1:0] MuxArd,
    input  logic [DATA_W-1:0] MuxDout,
    output logic              Busy
);

    state_t            state;
    rid_t              last;
    rid_t              owner;
    rid_t              gid;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              xfer;
    logic [ADDR_W-1:0] gaddr;

    assign req = {ReqB, ReqA};

    rr_arb2 u_arb (
        .req   (req),
        .last  (last),
        .stall (Stall),
        .gnt   (gnt)
    );

    assign GntA  = gnt[0];
    assign GntB  = gnt[1];
    assign xfer  = |(req & gnt);
    assign gid   = (req[1] & gnt[1]) ? REQ_B : REQ_A;
    assign gaddr = (gid == REQ_B) ? ArdB : ArdA;
    assign Busy  = (state == READ);

    // Capture uses the previous owner; a new grant may replace it
    // on the same edge, giving one read per cycle.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= IDLE;
            last    <= REQ_B;
            owner   <= REQ_A;
            MuxArd  <= '0;
            RdataA  <= '0;
            RdataB  <= '0;
            RvalidA <= 1'b0;
            RvalidB <= 1'b0;
        end else if (Stall) begin
            RvalidA <= 1'b0;
            RvalidB <= 1'b0;
        end else begin
            RvalidA <= 1'b0;
            RvalidB <= 1'b0;
            if (state == READ) begin
                if (owner == REQ_B) begin
                    RdataB  <= MuxDout;
                    RvalidB <= 1'b1;
                end else begin
                    RdataA  <= MuxDout;
                    RvalidA <= 1'b1;
                end
            end
            if (xfer) begin
                MuxArd <= gaddr;
                owner  <= gid;
                last   <= gid;
                state  <= READ;
            end else begin
                state  <= IDLE;
            end
        end
    end

endmodule
